sram_port_arbiter: RTL and testbench
====================================

// Module: sram_port_arbiter
// PURPOSE
// - Shares one single-port synchronous SRAM (1-cycle read latency) between two requesters.
// - M0 is the core data port (dcache_*); M1 is a secondary master (loader/debug/DMA).
// - Grants one request per cycle, steers each response back to its originator,
//   and guarantees M1 forward progress under continuous M0 traffic.
// PARAMETERS
// - ADDR_W    32  address width, all ports
// - DATA_W    32  data width, all ports
// - MAX_HOLD  8   max consecutive M0 grants while M1 waits (fixed-priority mode); >=1
// PORTS
// - clk_i         in   1       clock, all state on rising edge
// - rst_i         in   1       asynchronous reset, active-high
// - mN_req_i      in   1       N=0,1: request valid; held with fields stable until granted
// - mN_we_i       in   1       1=write, 0=read
// - mN_addr_i     in   ADDR_W  byte address, passed through unmodified
// - mN_wdata_i    in   DATA_W  write data
// - mN_gnt_o      out  1       request accepted this cycle (combinational from req)
// - mN_rvalid_o   out  1       response for a granted transaction, one cycle after gnt
// - mN_rdata_o    out  DATA_W  read data; valid when mN_rvalid_o && granted op was a read
// - sram_req_o    out  1       SRAM access this cycle
// - sram_we_o     out  1       SRAM write enable
// - sram_addr_o   out  ADDR_W  SRAM address
// - sram_wdata_o  out  DATA_W  SRAM write data
// - sram_rdata_i  in   DATA_W  SRAM read data, valid the cycle after a read access
// BEHAVIOUR
// - Reset (async, rst_i=1): gnt/rvalid/sram_req/sram_we = 0; rdata/addr/wdata = 0;
//   hold counter = 0; FSM = S_NORMAL; rr pointer = M1 (M0 wins first tie).
// - Grant is combinational: at most one gnt per cycle. sram_* carry the winner's fields
//   in the same cycle. No request -> sram_req_o=0 and sram_* fields = 0.
// - Response: registered owner id + valid; next cycle mOwner_rvalid_o=1 for one cycle,
//   reads and writes alike. Both mN_rdata_o = sram_rdata_i on every rvalid cycle;
//   content is undefined for writes. Other requester's rvalid stays 0.
// - Back-to-back: a new grant may issue in the same cycle as the previous response.
//   Throughput is 1 transaction/cycle.
// - FSM (fixed priority, default build):
//   - S_NORMAL: M0 wins any conflict. Cycle with m0 gnt && m1_req: cnt++.
//     Cycle where M1 is granted, or m1_req=0: cnt <= 0.
//     Grant to M0 with cnt==MAX_HOLD-1 && m1_req -> S_STARVE.
//   - S_STARVE: M1 granted unconditionally (M0 stalls) -> S_NORMAL, cnt <= 0.
//     If m1_req dropped (protocol violation), grant M0 normally and return to S_NORMAL.
// - Sole requester is always granted the same cycle, in any state.
// - Simultaneous same-address read (M1) and write (M0): serialised by grant order; no forwarding.
// - Reset mid-operation: an in-flight response is dropped (no rvalid after reset release).
//   Requesters re-issue.
// - Assertions (sim only): gnt one-hot0; no gnt without req; req held until gnt.
// CONFIGURATION
// - ARB_ROUND_ROBIN_EN defined:
//   - Conflicts go to the requester not granted last. rr pointer updates on every grant.
//   - Hold counter and S_STARVE are not built; MAX_HOLD is ignored.
// - Undefined: fixed priority M0 > M1 with the MAX_HOLD starvation guard (above).
// TESTING
// - M0 read 0x10 alone -> m0_gnt=1 same cycle, sram_addr=0x10;
//   next cycle m0_rvalid=1 with SRAM data; m1_rvalid=0.
// - M0 write 0x20=0xDEADBEEF, then M1 read 0x20 -> M1 gets 0xDEADBEEF one cycle after its gnt.
// - Both requesting continuously, MAX_HOLD=8, fixed mode -> grant pattern 8x M0, 1x M1,
//   repeating; rvalid owners follow one cycle later.
// - ARB_ROUND_ROBIN_EN, both requesting continuously -> grants alternate M0,M1,M0,...
//   with M0 first after reset.
// - Assert rst_i the cycle after an M1 read gnt -> m1_rvalid never asserts;
//   all outputs 0 during reset; first post-reset tie goes to M0.
// - Back-to-back M0 reads 0x0,0x4,0x8 -> three consecutive gnts,
//   three consecutive rvalids with matching data.

Source files
------------

// File: rtl/sram_port_arbiter.sv
// ---------------------------------------------------------------------------
// sram_port_arbiter
//
// Shares one single-port synchronous SRAM (1-cycle read latency) between two
// requesters. M0 is the core data port and M1 is a secondary master (loader,
// debug or DMA). At most one request is granted per cycle. The grant is
// combinational, so the winner's fields go straight to the SRAM in the same
// cycle. The response is steered back to its originator one cycle later.
//
// Arbitration modes (compile-time macro ARB_ROUND_ROBIN_EN):
//   undefined : fixed priority M0 > M1. A hold counter forces one M1 grant
//               after MAX_HOLD consecutive M0 grants taken while M1 waited.
//   defined   : round robin. A conflict goes to the requester that was not
//               granted last. MAX_HOLD is ignored.
//
// Ports
//   clk_i          clock, all state on the rising edge
//   rst_i          asynchronous reset, active-high
//   mN_req_i       request valid; held with fields stable until granted
//   mN_we_i        1 = write, 0 = read
//   mN_addr_i      byte address, passed through unmodified
//   mN_wdata_i     write data
//   mN_gnt_o       request accepted this cycle (combinational)
//   mN_rvalid_o    response strobe, one cycle after the grant
//   mN_rdata_o     read data, valid with mN_rvalid_o for reads
//   sram_req_o     SRAM access this cycle
//   sram_we_o      SRAM write enable
//   sram_addr_o    SRAM address
//   sram_wdata_o   SRAM write data
//   sram_rdata_i   SRAM read data, valid the cycle after a read access
// ---------------------------------------------------------------------------
module sram_port_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_HOLD = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,

    input  logic              m0_req_i,
    input  logic              m0_we_i,
    input  logic [ADDR_W-1:0] m0_addr_i,
    input  logic [DATA_W-1:0] m0_wdata_i,
    output logic              m0_gnt_o,
    output logic              m0_rvalid_o,
    output logic [DATA_W-1:0] m0_rdata_o,

    input  logic              m1_req_i,
    input  logic              m1_we_i,
    input  logic [ADDR_W-1:0] m1_addr_i,
    input  logic [DATA_W-1:0] m1_wdata_i,
    output logic              m1_gnt_o,
    output logic              m1_rvalid_o,
    output logic [DATA_W-1:0] m1_rdata_o,

    output logic              sram_req_o,
    output logic              sram_we_o,
    output logic [ADDR_W-1:0] sram_addr_o,
    output logic [DATA_W-1:0] sram_wdata_o,
    input  logic [DATA_W-1:0] sram_rdata_i
);

    logic grant0;
    logic grant1;

`ifdef ARB_ROUND_ROBIN_EN
    // -----------------------------------------------------------------------
    // Round robin: rr_q holds the id of the requester granted last. It resets
    // to M1 so that M0 wins the first tie.
    // -----------------------------------------------------------------------
    logic rr_q;
    logic rr_d;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so
        // no path through the block leaves it unassigned and infers a latch.
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (m0_req_i && m1_req_i) begin
            grant0 = rr_q;
            grant1 = !rr_q;
        end else begin
            grant0 = m0_req_i;
            grant1 = m1_req_i;
        end
        // No grant may be issued while reset is asserted.
        if (rst_i) begin
            grant0 = 1'b0;
            grant1 = 1'b0;
        end
    end

    always_comb begin
        rr_d = rr_q;
        if (grant1) begin
            rr_d = 1'b1;
        end else if (grant0) begin
            rr_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr_q <= 1'b1;
        end else begin
            rr_q <= rr_d;
        end
    end
`else
    // -----------------------------------------------------------------------
    // Fixed priority with starvation guard. cnt_q counts consecutive M0 grants
    // taken while M1 waited. The M0 grant that brings it to MAX_HOLD moves the
    // FSM to S_STARVE, where M1 gets the next cycle unconditionally.
    // -----------------------------------------------------------------------
    localparam int CNT_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_HOLD - 1);

    localparam logic [0:0] S_NORMAL = 1'b0;
    localparam logic [0:0] S_STARVE = 1'b1;

    logic [0:0]       state_q;
    logic [0:0]       state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so
        // no path through the block leaves it unassigned and infers a latch.
        grant0  = 1'b0;
        grant1  = 1'b0;
        state_d = state_q;
        cnt_d   = cnt_q;

        if ((state_q == S_STARVE) && m1_req_i) begin
            grant1  = 1'b1;
            state_d = S_NORMAL;
            cnt_d   = '0;
        end else begin
            // S_NORMAL, or S_STARVE after M1 illegally withdrew its request:
            // plain fixed priority, and the FSM settles back in S_NORMAL.
            grant0  = m0_req_i;
            grant1  = m1_req_i && !m0_req_i;
            state_d = S_NORMAL;
            if (grant0 && m1_req_i) begin
                if (cnt_q == CNT_LAST) begin
                    state_d = S_STARVE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end else begin
                cnt_d = '0;
            end
        end

        // No grant may be issued while reset is asserted.
        if (rst_i) begin
            grant0 = 1'b0;
            grant1 = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_NORMAL;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end
`endif

    // -----------------------------------------------------------------------
    // SRAM request steering: the winner's fields, or all zero when idle.
    // -----------------------------------------------------------------------
    always_comb begin
        sram_we_o    = 1'b0;
        sram_addr_o  = '0;
        sram_wdata_o = '0;
        if (grant0) begin
            sram_we_o    = m0_we_i;
            sram_addr_o  = m0_addr_i;
            sram_wdata_o = m0_wdata_i;
        end else if (grant1) begin
            sram_we_o    = m1_we_i;
            sram_addr_o  = m1_addr_i;
            sram_wdata_o = m1_wdata_i;
        end
    end

    assign sram_req_o = grant0 | grant1;
    assign m0_gnt_o   = grant0;
    assign m1_gnt_o   = grant1;

    // -----------------------------------------------------------------------
    // Response tracking: one outstanding slot, because the SRAM returns data
    // exactly one cycle after the access. A new grant may overlap the previous
    // response. Reset clears the slot, so an in-flight response is dropped.
    // -----------------------------------------------------------------------
    logic rvalid_q;
    logic owner_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        // NOTE: sequential state uses non-blocking assignments, so every
        // register samples pre-edge values regardless of statement order.
        if (rst_i) begin
            rvalid_q <= 1'b0;
            owner_q  <= 1'b0;
        end else begin
            rvalid_q <= grant0 | grant1;
            owner_q  <= grant1;
        end
    end

    logic [DATA_W-1:0] rdata_mux;
    assign rdata_mux = rvalid_q ? sram_rdata_i : '0;

    assign m0_rvalid_o = rvalid_q && !owner_q;
    assign m1_rvalid_o = rvalid_q && owner_q;
    // Both requesters see the SRAM data; only the owner's rvalid qualifies it.
    assign m0_rdata_o  = rdata_mux;
    assign m1_rdata_o  = rdata_mux;

`ifndef SYNTHESIS
    a_gnt_onehot0: assert property (@(posedge clk_i) disable iff (rst_i)
        !(m0_gnt_o && m1_gnt_o));
    a_m0_gnt_req: assert property (@(posedge clk_i) disable iff (rst_i)
        m0_gnt_o |-> m0_req_i);
    a_m1_gnt_req: assert property (@(posedge clk_i) disable iff (rst_i)
        m1_gnt_o |-> m1_req_i);
    a_m0_hold: assert property (@(posedge clk_i) disable iff (rst_i)
        (m0_req_i && !m0_gnt_o) |=>
        (m0_req_i && $stable({m0_we_i, m0_addr_i, m0_wdata_i})));
    a_m1_hold: assert property (@(posedge clk_i) disable iff (rst_i)
        (m1_req_i && !m1_gnt_o) |=>
        (m1_req_i && $stable({m1_we_i, m1_addr_i, m1_wdata_i})));
`endif

endmodule

// File: tb/tb_sram_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sram_port_arbiter
//
// Directed bench for sram_port_arbiter. A small SRAM model answers reads one
// cycle after the access. Unwritten words read back as 0xA500_0000 | address,
// so expected read data can be worked out by hand from the address alone.
// Inputs change 1 time unit after the rising edge. Outputs are sampled on the
// falling edge.
// ---------------------------------------------------------------------------
module tb_sram_port_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              m0_req_i, m0_we_i, m1_req_i, m1_we_i;
    logic [ADDR_W-1:0] m0_addr_i, m1_addr_i;
    logic [DATA_W-1:0] m0_wdata_i, m1_wdata_i;
    logic              m0_gnt_o, m0_rvalid_o, m1_gnt_o, m1_rvalid_o;
    logic [DATA_W-1:0] m0_rdata_o, m1_rdata_o;
    logic              sram_req_o, sram_we_o;
    logic [ADDR_W-1:0] sram_addr_o;
    logic [DATA_W-1:0] sram_wdata_o;
    logic [DATA_W-1:0] sram_rdata_i;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk_i = ~clk_i;

    sram_port_arbiter #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .MAX_HOLD(8)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .m0_req_i     (m0_req_i),
        .m0_we_i      (m0_we_i),
        .m0_addr_i    (m0_addr_i),
        .m0_wdata_i   (m0_wdata_i),
        .m0_gnt_o     (m0_gnt_o),
        .m0_rvalid_o  (m0_rvalid_o),
        .m0_rdata_o   (m0_rdata_o),
        .m1_req_i     (m1_req_i),
        .m1_we_i      (m1_we_i),
        .m1_addr_i    (m1_addr_i),
        .m1_wdata_i   (m1_wdata_i),
        .m1_gnt_o     (m1_gnt_o),
        .m1_rvalid_o  (m1_rvalid_o),
        .m1_rdata_o   (m1_rdata_o),
        .sram_req_o   (sram_req_o),
        .sram_we_o    (sram_we_o),
        .sram_addr_o  (sram_addr_o),
        .sram_wdata_o (sram_wdata_o),
        .sram_rdata_i (sram_rdata_i)
    );

    // SRAM model: 256 words, 1-cycle read latency.
    logic [31:0] mem     [256];
    bit          written [256];

    always @(posedge clk_i) begin
        if (sram_req_o) begin
            if (sram_we_o) begin
                mem[sram_addr_o[9:2]]     <= sram_wdata_o;
                written[sram_addr_o[9:2]] <= 1'b1;
            end else if (written[sram_addr_o[9:2]]) begin
                sram_rdata_i <= mem[sram_addr_o[9:2]];
            end else begin
                sram_rdata_i <= 32'hA500_0000 | {22'd0, sram_addr_o[9:2], 2'b00};
            end
        end
    end

    // Drive both requesters (called right after an input-change point).
    task automatic drive(input logic r0, input logic w0, input logic [31:0] a0,
                         input logic [31:0] d0, input logic r1, input logic w1,
                         input logic [31:0] a1, input logic [31:0] d1);
        m0_req_i = r0; m0_we_i = w0; m0_addr_i = a0; m0_wdata_i = d0;
        m1_req_i = r1; m1_we_i = w1; m1_addr_i = a1; m1_wdata_i = d1;
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_cycle();
        step();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk_i);
    endtask

    // -----------------------------------------------------------------------
    task automatic test_reset();
        @(negedge clk_i);
        n_vec++; if (m0_gnt_o !== 1'b0 || m1_gnt_o !== 1'b0) begin n_miss++;
            $display("FAIL reset_gnt got %b%b exp 00", m0_gnt_o, m1_gnt_o); end
        n_vec++; if (sram_req_o !== 1'b0 || sram_we_o !== 1'b0 || sram_addr_o !== 32'd0) begin n_miss++;
            $display("FAIL reset_sram got req=%b we=%b addr=%h exp 0/0/0", sram_req_o, sram_we_o, sram_addr_o); end
        n_vec++; if (m0_rvalid_o !== 1'b0 || m1_rvalid_o !== 1'b0 || m0_rdata_o !== 32'd0) begin n_miss++;
            $display("FAIL reset_rvalid got %b%b rdata=%h exp 00 0", m0_rvalid_o, m1_rvalid_o, m0_rdata_o); end
        step();
        rst_i = 1'b0;
        @(negedge clk_i);
        n_vec++; if (sram_req_o !== 1'b0 || sram_addr_o !== 32'd0) begin n_miss++;
            $display("FAIL idle_sram got req=%b addr=%h exp 0/0", sram_req_o, sram_addr_o); end
    endtask

    // M0 read 0x10 alone.
    task automatic test_single_read();
        step();
        drive(1, 0, 32'h10, 0, 0, 0, 0, 0);
        @(negedge clk_i);
        n_vec++; if (m0_gnt_o !== 1'b1 || m1_gnt_o !== 1'b0) begin n_miss++;
            $display("FAIL rd_gnt got %b%b exp 10", m0_gnt_o, m1_gnt_o); end
        n_vec++; if (sram_req_o !== 1'b1 || sram_we_o !== 1'b0 || sram_addr_o !== 32'h10) begin n_miss++;
            $display("FAIL rd_sram got req=%b we=%b addr=%h exp 1/0/10", sram_req_o, sram_we_o, sram_addr_o); end
        step();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk_i);
        n_vec++; if (m0_rvalid_o !== 1'b1 || m1_rvalid_o !== 1'b0) begin n_miss++;
            $display("FAIL rd_rvalid got %b%b exp 10", m0_rvalid_o, m1_rvalid_o); end
        n_vec++; if (m0_rdata_o !== 32'hA500_0010) begin n_miss++;
            $display("FAIL rd_data got %h exp a5000010", m0_rdata_o); end
        idle_cycle();
        n_vec++; if (m0_rvalid_o !== 1'b0) begin n_miss++;
            $display("FAIL rd_rvalid_pulse got %b exp 0", m0_rvalid_o); end
    endtask

    // M0 write 0x20 = DEADBEEF, then M1 read 0x20.
    task automatic test_write_then_read();
        step();
        drive(1, 1, 32'h20, 32'hDEAD_BEEF, 0, 0, 0, 0);
        @(negedge clk_i);
        n_vec++; if (m0_gnt_o !== 1'b1 || sram_we_o !== 1'b1 || sram_wdata_o !== 32'hDEAD_BEEF) begin n_miss++;
            $display("FAIL wr_issue got gnt=%b we=%b wdata=%h exp 1/1/deadbeef", m0_gnt_o, sram_we_o, sram_wdata_o); end
        step();
        drive(0, 0, 0, 0, 1, 0, 32'h20, 0);
        @(negedge clk_i);
        n_vec++; if (m1_gnt_o !== 1'b1 || m0_gnt_o !== 1'b0 || sram_we_o !== 1'b0 || sram_addr_o !== 32'h20) begin n_miss++;
            $display("FAIL wr_rd_issue got gnt=%b%b we=%b addr=%h exp 01/0/20", m0_gnt_o, m1_gnt_o, sram_we_o, sram_addr_o); end
        n_vec++; if (m0_rvalid_o !== 1'b1 || m1_rvalid_o !== 1'b0) begin n_miss++;
            $display("FAIL wr_resp got %b%b exp 10", m0_rvalid_o, m1_rvalid_o); end
        step();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk_i);
        n_vec++; if (m1_rvalid_o !== 1'b1 || m0_rvalid_o !== 1'b0) begin n_miss++;
            $display("FAIL wr_rd_rvalid got %b%b exp 01", m0_rvalid_o, m1_rvalid_o); end
        n_vec++; if (m1_rdata_o !== 32'hDEAD_BEEF) begin n_miss++;
            $display("FAIL wr_rd_data got %h exp deadbeef", m1_rdata_o); end
        idle_cycle();
    endtask

    // Both requesting continuously. Fixed mode: 8x M0 then 1x M1 (period 9).
    // Round robin: alternate, M0 first (period 2).
    task automatic test_contention();
        int period;
        bit exp1, prev1;
`ifdef ARB_ROUND_ROBIN_EN
        period = 2;
`else
        period = 9;
`endif
        step();
        drive(1, 0, 32'h0, 0, 1, 0, 32'h4, 0);
        for (int k = 0; k < 18; k++) begin
            @(negedge clk_i);
            exp1 = ((k % period) == period - 1);
            n_vec++; if (m0_gnt_o !== !exp1 || m1_gnt_o !== exp1) begin n_miss++;
                $display("FAIL cont_gnt k=%0d got %b%b exp %b%b", k, m0_gnt_o, m1_gnt_o, !exp1, exp1); end
            n_vec++; if (sram_addr_o !== (exp1 ? 32'h4 : 32'h0)) begin n_miss++;
                $display("FAIL cont_addr k=%0d got %h exp %h", k, sram_addr_o, exp1 ? 32'h4 : 32'h0); end
            if (k > 0) begin
                prev1 = (((k - 1) % period) == period - 1);
                n_vec++; if (m0_rvalid_o !== !prev1 || m1_rvalid_o !== prev1) begin n_miss++;
                    $display("FAIL cont_rvalid k=%0d got %b%b exp %b%b", k, m0_rvalid_o, m1_rvalid_o, !prev1, prev1); end
            end
        end
        // k=17 granted M1; M0 is still waiting, finish it alone.
        step();
        drive(1, 0, 32'h0, 0, 0, 0, 0, 0);
        @(negedge clk_i);
        n_vec++; if (m0_gnt_o !== 1'b1 || m1_rvalid_o !== 1'b1 || m1_rdata_o !== 32'hA500_0004) begin n_miss++;
            $display("FAIL cont_tail got gnt0=%b rv1=%b rdata=%h exp 1/1/a5000004", m0_gnt_o, m1_rvalid_o, m1_rdata_o); end
        idle_cycle();
    endtask

    // Reset asserted the cycle after an M1 read grant.
    task automatic test_reset_mid_op();
        step();
        drive(0, 0, 0, 0, 1, 0, 32'h8, 0);
        @(negedge clk_i);
        n_vec++; if (m1_gnt_o !== 1'b1) begin n_miss++;
            $display("FAIL rst_mid_gnt got %b exp 1", m1_gnt_o); end
        step();
        rst_i = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk_i);
        n_vec++; if (m1_rvalid_o !== 1'b0 || m1_rdata_o !== 32'd0) begin n_miss++;
            $display("FAIL rst_mid_drop got rv=%b rdata=%h exp 0/0", m1_rvalid_o, m1_rdata_o); end
        step();
        drive(1, 0, 32'h0, 0, 1, 0, 32'hC, 0);
        @(negedge clk_i);
        n_vec++; if (m0_gnt_o !== 1'b0 || m1_gnt_o !== 1'b0 || sram_req_o !== 1'b0 || sram_addr_o !== 32'd0) begin n_miss++;
            $display("FAIL rst_mid_outs got gnt=%b%b req=%b addr=%h exp 00/0/0", m0_gnt_o, m1_gnt_o, sram_req_o, sram_addr_o); end
        step();
        rst_i = 1'b0;
        @(negedge clk_i);
        n_vec++; if (m0_gnt_o !== 1'b1 || m1_gnt_o !== 1'b0 || m1_rvalid_o !== 1'b0) begin n_miss++;
            $display("FAIL rst_tie got gnt=%b%b rv1=%b exp 10/0", m0_gnt_o, m1_gnt_o, m1_rvalid_o); end
        step();
        drive(0, 0, 0, 0, 1, 0, 32'hC, 0);
        @(negedge clk_i);
        n_vec++; if (m1_gnt_o !== 1'b1 || sram_addr_o !== 32'hC || m0_rvalid_o !== 1'b1 || m0_rdata_o !== 32'hA500_0000) begin n_miss++;
            $display("FAIL rst_sole_m1 got gnt1=%b addr=%h rv0=%b rdata=%h exp 1/c/1/a5000000", m1_gnt_o, sram_addr_o, m0_rvalid_o, m0_rdata_o); end
        step();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk_i);
        n_vec++; if (m1_rvalid_o !== 1'b1 || m0_rvalid_o !== 1'b0 || m1_rdata_o !== 32'hA500_000C) begin n_miss++;
            $display("FAIL rst_after_rd got rv=%b%b rdata=%h exp 01/a500000c", m0_rvalid_o, m1_rvalid_o, m1_rdata_o); end
        idle_cycle();
    endtask

    // M0 reads 0x0, 0x4, 0x8 on consecutive cycles.
    task automatic test_back_to_back();
        logic [31:0] exp_d;
        for (int k = 0; k < 4; k++) begin
            step();
            if (k < 3) drive(1, 0, 32'(k * 4), 0, 0, 0, 0, 0);
            else       drive(0, 0, 0, 0, 0, 0, 0, 0);
            @(negedge clk_i);
            n_vec++; if (m0_gnt_o !== (k < 3)) begin n_miss++;
                $display("FAIL b2b_gnt k=%0d got %b exp %b", k, m0_gnt_o, k < 3); end
            n_vec++; if (m0_rvalid_o !== (k >= 1)) begin n_miss++;
                $display("FAIL b2b_rvalid k=%0d got %b exp %b", k, m0_rvalid_o, k >= 1); end
            if (k >= 1) begin
                exp_d = 32'hA500_0000 | 32'((k - 1) * 4);
                n_vec++; if (m0_rdata_o !== exp_d) begin n_miss++;
                    $display("FAIL b2b_data k=%0d got %h exp %h", k, m0_rdata_o, exp_d); end
            end
        end
        idle_cycle();
    endtask

    initial begin
        rst_i = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        test_reset();
        test_single_read();
        test_write_then_read();
        test_contention();
        test_reset_mid_op();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
